// File: rtl/booth_pkg.sv
// Shared widths, FSM encoding and captured-bus layout for the Booth
// partial-product accumulator.
package booth_pkg;

   localparam int NUM_PP = 17;
   localparam int PP_W   = 34;
   localparam int PP16_W = 32;
   localparam int EC_W   = 16;
   localparam int PROD_W = 64;
   // Term index must hold the largest look-ahead index (16 + 16) without wrapping.
   localparam int IDX_W  = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;

   typedef struct packed {
      logic [EC_W-1:0][PP_W-1:0] pp;
      logic [PP16_W-1:0]         pp16;
      logic [EC_W-1:0]           ec;
   } pp_set_t;

endpackage

// File: rtl/booth_pp_weight.sv
// Turns one Booth term (PP0..PP15 with its correction bit, or PP16) into its
// 64-bit weighted contribution; indices past the last term contribute zero.
module booth_pp_weight
   import booth_pkg::*;
(
   input  logic [IDX_W-1:0]       idx_i,
   input  logic signed [PP_W-1:0] pp_i,
   input  logic                   ec_i,
   output logic [PROD_W-1:0]      term_o
);

   logic [PROD_W-1:0] pp_sx;

   always_comb begin
      pp_sx  = {{(PROD_W-PP_W){pp_i[PP_W-1]}}, pp_i};
      term_o = '0;
      if (idx_i < IDX_W'(EC_W)) begin
         term_o = (pp_sx + PROD_W'(ec_i)) << {idx_i[3:0], 1'b0};
      end else if (idx_i == IDX_W'(NUM_PP - 1)) begin
         // Unsigned-mode correction: zero-extended, fixed weight 2^32.
         term_o = {pp_i[PP16_W-1:0], {(PROD_W-PP16_W){1'b0}}};
      end
   end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential Booth PP reducer: captures one PP set, sums PP_PER_CYCLE weighted
// terms per clock into a 64-bit accumulator, then holds the product on a valid/ready port.
module booth_pp_accumulator
   import booth_pkg::*;
#(
   parameter int PP_PER_CYCLE = 1
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   In_Valid,
   output logic                   In_Ready,
   input  logic [EC_W-1:0]        Error_Correction,
   input  logic signed [PP_W-1:0] PP0,
   input  logic signed [PP_W-1:0] PP1,
   input  logic signed [PP_W-1:0] PP2,
   input  logic signed [PP_W-1:0] PP3,
   input  logic signed [PP_W-1:0] PP4,
   input  logic signed [PP_W-1:0] PP5,
   input  logic signed [PP_W-1:0] PP6,
   input  logic signed [PP_W-1:0] PP7,
   input  logic signed [PP_W-1:0] PP8,
   input  logic signed [PP_W-1:0] PP9,
   input  logic signed [PP_W-1:0] PP10,
   input  logic signed [PP_W-1:0] PP11,
   input  logic signed [PP_W-1:0] PP12,
   input  logic signed [PP_W-1:0] PP13,
   input  logic signed [PP_W-1:0] PP14,
   input  logic signed [PP_W-1:0] PP15,
   input  logic [PP16_W-1:0]      PP16,
   output logic [PROD_W-1:0]      Product,
   output logic                   Out_Valid,
   input  logic                   Out_Ready
);

   acc_state_t        state_q, state_d;
   pp_set_t           pp_q, pp_d, in_set;
   logic [PROD_W-1:0] acc_q, acc_d;
   logic [PROD_W-1:0] prod_q, prod_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [PROD_W-1:0] term [PP_PER_CYCLE];
   logic [PROD_W-1:0] sum;
   logic [IDX_W-1:0]  idx_next;
   logic              last_cycle;

   always_comb begin
      in_set.pp[0]  = PP0;
      in_set.pp[1]  = PP1;
      in_set.pp[2]  = PP2;
      in_set.pp[3]  = PP3;
      in_set.pp[4]  = PP4;
      in_set.pp[5]  = PP5;
      in_set.pp[6]  = PP6;
      in_set.pp[7]  = PP7;
      in_set.pp[8]  = PP8;
      in_set.pp[9]  = PP9;
      in_set.pp[10] = PP10;
      in_set.pp[11] = PP11;
      in_set.pp[12] = PP12;
      in_set.pp[13] = PP13;
      in_set.pp[14] = PP14;
      in_set.pp[15] = PP15;
      in_set.pp16   = PP16;
      in_set.ec     = Error_Correction;
   end

   // Term select: lane k handles term idx_q + k from the captured set.
   for (genvar k = 0; k < PP_PER_CYCLE; k++) begin : g_term
      logic [IDX_W-1:0]       t_idx;
      logic signed [PP_W-1:0] t_pp;
      logic                   t_ec;

      always_comb begin
         t_idx = idx_q + IDX_W'(k);
         t_pp  = '0;
         t_ec  = 1'b0;
         if (t_idx < IDX_W'(EC_W)) begin
            t_pp = pp_q.pp[t_idx[3:0]];
            t_ec = pp_q.ec[t_idx[3:0]];
         end else if (t_idx == IDX_W'(NUM_PP - 1)) begin
            t_pp = {{(PP_W-PP16_W){1'b0}}, pp_q.pp16};
         end
      end

      booth_pp_weight u_weight (
         .idx_i  (t_idx),
         .pp_i   (t_pp),
         .ec_i   (t_ec),
         .term_o (term[k])
      );
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < PP_PER_CYCLE; k++) begin
         sum = sum + term[k];
      end
   end

   assign idx_next   = idx_q + IDX_W'(PP_PER_CYCLE);
   assign last_cycle = (idx_next >= IDX_W'(NUM_PP));

   always_comb begin
      state_d   = state_q;
      pp_d      = pp_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      prod_d    = prod_q;
      In_Ready  = 1'b0;
      Out_Valid = 1'b0;
      case (state_q)
         IDLE: begin
            In_Ready = ~Rst;
            if (In_Valid) begin
               pp_d    = in_set;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_q + sum;
            idx_d = idx_next;
            if (last_cycle) begin
               prod_d  = acc_q + sum;
               state_d = DONE;
            end
         end
         DONE: begin
            // Gated so a reset in DONE never shows as a completed handshake.
            Out_Valid = ~Rst;
            if (Out_Ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         pp_q    <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         pp_q    <= pp_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         prod_q  <= prod_d;
      end
   end

   assign Product = prod_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Bench for booth_pp_accumulator: Booth-encodes operand pairs and compares the
// product, latency and throughput against a plain 64-bit multiply reference.
module tb_booth_pp_accumulator;

   parameter int PP_PER_CYCLE = 1;
   localparam int C = (17 + PP_PER_CYCLE - 1) / PP_PER_CYCLE;

   logic               Clk;
   logic               Rst;
   logic               In_Valid;
   logic               In_Ready;
   logic [15:0]        Error_Correction;
   logic signed [33:0] pp [16];
   logic [31:0]        PP16;
   logic [63:0]        Product;
   logic               Out_Valid;
   logic               Out_Ready;

   int n_vec = 0;
   int n_mis = 0;

   booth_pp_accumulator #(.PP_PER_CYCLE(PP_PER_CYCLE)) dut (
      .Clk              (Clk),
      .Rst              (Rst),
      .In_Valid         (In_Valid),
      .In_Ready         (In_Ready),
      .Error_Correction (Error_Correction),
      .PP0  (pp[0]),  .PP1  (pp[1]),  .PP2  (pp[2]),  .PP3  (pp[3]),
      .PP4  (pp[4]),  .PP5  (pp[5]),  .PP6  (pp[6]),  .PP7  (pp[7]),
      .PP8  (pp[8]),  .PP9  (pp[9]),  .PP10 (pp[10]), .PP11 (pp[11]),
      .PP12 (pp[12]), .PP13 (pp[13]), .PP14 (pp[14]), .PP15 (pp[15]),
      .PP16             (PP16),
      .Product          (Product),
      .Out_Valid        (Out_Valid),
      .Out_Ready        (Out_Ready)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b, input bit uns);
      longint sa, sb;
      if (uns) return {32'h0, a} * {32'h0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
   endfunction

   // Radix-4 Booth encoder: negative digits become one's complement plus EC bit.
   task automatic apply(input logic [31:0] a, input logic [31:0] b, input bit uns);
      logic [32:0] bx;
      longint      ax, mag;
      int          d, ad;
      bx = {b, 1'b0};
      ax = uns ? longint'({32'h0, a}) : longint'($signed(a));
      for (int i = 0; i < 16; i++) begin
         d   = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
         ad  = (d < 0) ? -d : d;
         mag = longint'(ad) * ax;
         if (d < 0) begin
            pp[i]               = ~mag[33:0];
            Error_Correction[i] = 1'b1;
         end else begin
            pp[i]               = mag[33:0];
            Error_Correction[i] = 1'b0;
         end
      end
      PP16 = (uns && b[31]) ? a : 32'h0;
   endtask

   task automatic scramble();
      logic [63:0] r;
      for (int i = 0; i < 16; i++) begin
         r     = {$urandom, $urandom};
         pp[i] = r[33:0];
      end
      Error_Correction = 16'($urandom);
      PP16             = $urandom;
      In_Valid         = 1'($urandom_range(0, 1));
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Latency counts the handshake cycle itself, so Out_Valid is expected C+1 cycles on.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit uns,
                         input int hold, input bit rdy_early, input string tag);
      logic [63:0] exp, held;
      int          n;
      bit          ok;
      exp = golden(a, b, uns);
      chk({tag, "_in_ready"}, 64'(In_Ready), 64'd1);
      apply(a, b, uns);
      In_Valid  = 1'b1;
      Out_Ready = rdy_early;
      @(posedge Clk); #1;
      scramble();
      n = 1;
      while (!Out_Valid && n < 200) begin
         @(posedge Clk); #1;
         scramble();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(C + 1));
      chk({tag, "_product"}, Product, exp);
      if (!rdy_early && hold > 0) begin
         held = Product;
         ok   = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            scramble();
            if (!(Out_Valid === 1'b1 && Product === held && In_Ready === 1'b0)) ok = 1'b0;
         end
         chk({tag, "_backpressure"}, 64'(ok), 64'd1);
      end
      Out_Ready = 1'b1;
      @(posedge Clk); #1;
      Out_Ready = 1'b0;
      In_Valid  = 1'b0;
      chk({tag, "_done_vld"}, 64'(Out_Valid), 64'd0);
      chk({tag, "_idle_rdy"}, 64'(In_Ready), 64'd1);
      chk({tag, "_retained"}, Product, exp);
   endtask

   initial begin
      logic [63:0] exp_q[$];
      int          drv_q[$];
      logic [31:0] a, b;
      bit          uns, ok;
      int          cyc, sent, got, last_drive;

      Rst = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0;
      Error_Correction = '0; PP16 = '0;
      for (int i = 0; i < 16; i++) pp[i] = '0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_out_valid", 64'(Out_Valid), 64'd0);
      chk("rst_product", Product, 64'd0);
      chk("rst_in_ready", 64'(In_Ready), 64'd0);
      Rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(In_Ready), 64'd1);

      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, "uu_max");
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b1, "ss_min");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, "ss_m1");
      run_op($urandom, $urandom, 1'b0, 10, 1'b0, "bp");

      // Reset in the middle of an accumulation.
      apply($urandom, $urandom, 1'b1);
      In_Valid = 1'b1; Out_Ready = 1'b0;
      @(posedge Clk); #1;
      In_Valid = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      chk("midrst_out_valid", 64'(Out_Valid), 64'd0);
      chk("midrst_product", Product, 64'd0);
      chk("midrst_in_ready", 64'(In_Ready), 64'd0);
      Rst = 1'b0;
      #1;
      chk("midrst_release_rdy", 64'(In_Ready), 64'd1);
      ok = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(posedge Clk); #1;
         if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) ok = 1'b0;
      end
      chk("midrst_no_pulse", 64'(ok), 64'd1);
      run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 1'b0, "uu_after_rst");

      // Back-to-back stream with Out_Ready held high.
      Out_Ready  = 1'b1;
      cyc        = 0;
      sent       = 0;
      got        = 0;
      last_drive = 0;
      while (got < 100 && cyc < 100 * (C + 2) + 200) begin
         if (Out_Valid) begin
            if (exp_q.size() == 0) begin
               chk("b2b_spurious_valid", 64'(Out_Valid), 64'd0);
            end else begin
               chk("b2b_product", Product, exp_q.pop_front());
               chk("b2b_latency", 64'(cyc - drv_q.pop_front()), 64'(C + 1));
               got++;
            end
         end
         if (In_Ready && sent < 100) begin
            a   = pick_operand();
            b   = pick_operand();
            uns = 1'($urandom_range(0, 1));
            apply(a, b, uns);
            In_Valid = 1'b1;
            exp_q.push_back(golden(a, b, uns));
            drv_q.push_back(cyc);
            if (sent > 0) chk("b2b_period", 64'(cyc - last_drive), 64'(C + 2));
            last_drive = cyc;
            sent++;
         end else begin
            scramble();
            In_Valid = (sent < 100);
         end
         @(posedge Clk); #1;
         cyc++;
      end
      chk("b2b_results", 64'(got), 64'd100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/booth_pp_accumulator.md
Name: booth_pp_accumulator

Overview:
- Sequential consumer of the radix-4 Booth partial-product bus: 17 partial products plus the 16-bit error-correction vector.
- Captures one complete PP set per valid/ready handshake and accumulates PP_PER_CYCLE weighted terms per clock into a 64-bit product.
- Presents the product on a valid/ready output.
- Sits between the Booth PP generator and the multiplier result register. It is the area-lean alternative to a full Wallace/Dadda tree.

Parameters:
- PP_PER_CYCLE, 1: partial products summed per ACCUM cycle. Legal values are 1..17. ACCUM length C = ceil(17/PP_PER_CYCLE).

Ports:
- Clk  input  1  single clock; all state changes on its rising edge
- Rst  input  1  synchronous, active-high reset
- In_Valid  input  1  PP set present
- In_Ready  output  1  block can accept a PP set
- Error_Correction  input  16  bit i is the +1 correction for PPi at weight 4^i
- PP0..PP15  input  34 each  signed (two's-complement) Booth partial products at weight 4^i
- PP16  input  32  unsigned unsigned-mode correction term at weight 2^32
- Product  output  64  accumulated result
- Out_Valid  output  1  Product valid
- Out_Ready  input  1  downstream accepts Product

Behaviour:
- Arithmetic: Product = sum over i=0..15 of (sext64(PPi) + Error_Correction[i]) * 4^i, plus zext64(PP16) * 2^32, all modulo 2^64.
  - Signed and unsigned modes differ only in input content: PP16 = 0 in signed mode. No Sign input is required.
- Reset (Rst=1 at a clock edge): state=IDLE, In_Ready=0 during the reset cycle, Out_Valid=0, Product=0, accumulator and index cleared, captured PP registers cleared.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - In_Ready=1, Out_Valid=0.
  - In_Valid=1 captures all PP inputs and Error_Correction into holding registers, clears the accumulator and index, and goes to ACCUM.
- ACCUM:
  - In_Ready=0.
  - Each cycle adds terms index..index+PP_PER_CYCLE-1 (PP16 is term 16) to the accumulator.
  - The EC bit is added with its own PP; PP16 has no EC bit.
  - Terms beyond 16 contribute 0.
  - After C cycles, go to DONE.
- DONE:
  - Out_Valid=1 and Product = accumulator.
  - Product is held stable while Out_Valid=1 and Out_Ready=0.
  - Out_Ready=1 completes the handshake, then IDLE.
  - In_Ready=0 in DONE, so there is no overlap.
- Latency: input handshake at edge t gives Out_Valid=1 from edge t+C+1, where t+C+1 is the first cycle in DONE.
  - PP_PER_CYCLE=1: 18 cycles.
  - PP_PER_CYCLE=17: 2 cycles.
  - Throughput is one result per C+2 cycles with Out_Ready held high.
- Input changes while not in IDLE are ignored; only the captured copy is used.
- Product retains its last value after the output handshake until the next DONE.
- Reset mid-ACCUM or mid-DONE: the in-flight result is discarded with no Out_Valid pulse, and the block returns to IDLE the cycle after Rst deasserts.
- Out_Ready asserted outside DONE has no effect.

Decomposition:
- Shared package booth_pkg:
  - NUM_PP=17, PP_W=34, PP16_W=32, EC_W=16, PROD_W=64.
  - The acc_state_t enum {IDLE, ACCUM, DONE}.
  - A pp_set_t struct for the captured bus.
- Sub-module booth_pp_weight:
  - Combinational.
  - Inputs: term index, one PP and its EC bit.
  - Output: the weighted 64-bit term (sign-extended, +EC, shifted by 2*i; PP16 zero-extended, shifted by 32).
  - Instantiated PP_PER_CYCLE times, feeding a PP_PER_CYCLE-input adder into the accumulator.

Test Plan:
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF (PPs from a bench Booth model, PP16=0xFFFFFFFF), PP_PER_CYCLE=1 -> Out_Valid at cycle 18 after accept, Product=0xFFFFFFFE00000001.
- Signed 0x80000000 x 0x80000000, then signed -1 x -1 (PP16=0) -> Product=0x4000000000000000, then 0x0000000000000001.
- Backpressure: hold Out_Ready=0 for 10 cycles after DONE -> Out_Valid stays 1, Product stable, In_Ready=0 throughout. Raising Out_Ready gives IDLE next cycle.
- Reset asserted at ACCUM cycle 5 -> no Out_Valid pulse, Product=0, In_Ready=1 the cycle after Rst deasserts. The next operand pair 0x12345678 x 0x9ABCDEF0 unsigned -> 0x0B00EA4E242D2080.
- Back-to-back: 100 random signed/unsigned pairs with Out_Ready=1 and In_Valid=1 -> each Product matches the 64-bit golden multiply, one result every C+2 cycles. Inputs changed during ACCUM are ignored.
- PP_PER_CYCLE=17 and PP_PER_CYCLE=4 builds, rerun the random set -> latency 2 and 6 cycles respectively, identical Products.
